// File: rtl/ufm_read_arbiter.sv
// ufm_read_arbiter: round-robin burst read arbiter sharing one altufm parallel read port between two requesters
// Ports: CLK_10MHZ/nRST clock and async active-low reset;
//   reqN/addrN/lenN burst request, start word address, length minus 1 (N = 0,1);
//   gntN/rdataN/rvalidN/doneN/errN grant, returned word, word strobe, last-word strobe, timeout strobe;
//   ufm_addr/ufm_nread drive the altufm, ufm_data_valid/ufm_dataout come back from it.
module ufm_read_arbiter #(
  parameter int TIMEOUT_CYC = 255,
  parameter int MAX_BURST = 16,
  localparam int LW = $clog2(MAX_BURST)
) (
  input  logic          CLK_10MHZ,
  input  logic          nRST,
  input  logic          req0,
  input  logic [8:0]    addr0,
  input  logic [LW-1:0] len0,
  output logic          gnt0,
  output logic [15:0]   rdata0,
  output logic          rvalid0,
  output logic          done0,
  output logic          err0,
  input  logic          req1,
  input  logic [8:0]    addr1,
  input  logic [LW-1:0] len1,
  output logic          gnt1,
  output logic [15:0]   rdata1,
  output logic          rvalid1,
  output logic          done1,
  output logic          err1,
  output logic [8:0]    ufm_addr,
  output logic          ufm_nread,
  input  logic          ufm_data_valid,
  input  logic [15:0]   ufm_dataout
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DATA, RELEASE} state_t;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  state_t state_q, state_d;
  logic [8:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic nread_q, nread_d, dv_q, cur_q, cur_d, last_q, last_d;
  logic [1:0] gnt_q, gnt_d, rvalid_q, rvalid_d, done_q, done_d, err_q, err_d;
  logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic pe, sel;
  assign pe = ufm_data_valid & ~dv_q;
  // on a tie, the port not served last wins
  assign sel = (req0 & req1) ? ~last_q : req1;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    nread_d = nread_q;
    cur_d = cur_q;
    last_d = last_q;
    gnt_d = gnt_q;
    rvalid_d = '0;
    done_d = '0;
    err_d = '0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: if (req0 | req1) begin
        cur_d = sel;
        addr_d = sel ? addr1 : addr0;
        cnt_d = sel ? len1 : len0;
        gnt_d = sel ? 2'b10 : 2'b01;
        state_d = ISSUE;
      end
      ISSUE: begin
        nread_d = 1'b0;
        tmo_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DATA: begin
        tmo_d = tmo_q + 8'd1;
        // a word arriving on the timeout cycle is still delivered
        if (state_q == WAIT_DATA && pe) begin
          nread_d = 1'b1;
          rvalid_d[cur_q] = 1'b1;
          if (cur_q) rdata1_d = ufm_dataout;
          else rdata0_d = ufm_dataout;
          if (cnt_q == '0) begin
            done_d[cur_q] = 1'b1;
            state_d = RELEASE;
          end else begin
            cnt_d = cnt_q - LW'(1);
            addr_d = addr_q + 9'd1;
            state_d = ISSUE;
          end
        end else if (tmo_q == TMO_LAST) begin
          nread_d = 1'b1;
          err_d[cur_q] = 1'b1;
          state_d = RELEASE;
        end else if (state_q == WAIT_BUSY && !ufm_data_valid) begin
          // low data_valid covers both the falling edge and already-low at entry
          state_d = WAIT_DATA;
        end
      end
      RELEASE: begin
        gnt_d = '0;
        last_d = cur_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_10MHZ or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      nread_q <= 1'b1;
      dv_q <= 1'b0;
      cur_q <= 1'b0;
      last_q <= 1'b1;
      gnt_q <= '0;
      rvalid_q <= '0;
      done_q <= '0;
      err_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      nread_q <= nread_d;
      dv_q <= ufm_data_valid;
      cur_q <= cur_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      rvalid_q <= rvalid_d;
      done_q <= done_d;
      err_q <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign ufm_addr = addr_q;
  assign ufm_nread = nread_q;
  assign {gnt1, gnt0} = gnt_q;
  assign {rvalid1, rvalid0} = rvalid_q;
  assign {done1, done0} = done_q;
  assign {err1, err0} = err_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
endmodule
